seq_alu: RTL and testbench

- Multi-cycle, registered successor to the combinational datapath ALU.
- Performs the existing single-cycle op set plus iterative MUL (shift-add) and DIV/REM (restoring), all parametrised in operand width.
- Sits between the register-file read ports and the writeback mux; the controller uses Start/Busy/Done to stall fetch while a multi-cycle op is in flight.
- All results and flags are registered and held stable until the next completion.

---
 rtl/seq_alu.sv | 225 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU with single-cycle ops plus shift-add
// MUL and restoring DIV/REM.
// Ports: Clk, Reset_n (async, active low), Start/OP/InputA/InputB launch an
// operation; Busy marks MUL/DIV iteration, Done pulses once when
// Out/OutHi/Cond/Zero/DivZero/Illegal take their new, held values.
module seq_alu #(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    input  logic [Ops-1:0] OP,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    output logic           Busy,
    output logic           Done,
    output logic [W-1:0]   Out,
    output logic [W-1:0]   OutHi,
    output logic           Cond,
    output logic           Zero,
    output logic           DivZero,
    output logic           Illegal
);

    localparam int CW = $clog2(W + 1);

    localparam logic [Ops-1:0] OP_ADD = Ops'(0);
    localparam logic [Ops-1:0] OP_SUB = Ops'(1);
    localparam logic [Ops-1:0] OP_AND = Ops'(2);
    localparam logic [Ops-1:0] OP_OR  = Ops'(3);
    localparam logic [Ops-1:0] OP_NOT = Ops'(4);
    localparam logic [Ops-1:0] OP_XOR = Ops'(5);
    localparam logic [Ops-1:0] OP_LSH = Ops'(6);
    localparam logic [Ops-1:0] OP_RSH = Ops'(7);
    localparam logic [Ops-1:0] OP_SLT = Ops'(8);
    localparam logic [Ops-1:0] OP_SEQ = Ops'(9);
    localparam logic [Ops-1:0] OP_MUL = Ops'(10);
    localparam logic [Ops-1:0] OP_DIV = Ops'(11);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  opb_q, opb_d;
    logic          is_div_q, is_div_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  out_q, out_d;
    logic [W-1:0]  outhi_q, outhi_d;
    logic          cond_q, cond_d;
    logic          zero_q, zero_d;
    logic          divz_q, divz_d;
    logic          ill_q, ill_d;

    // Single-cycle result path
    logic [W-1:0]  sc_out;
    logic          sc_cond;
    logic          sc_ill;
    logic          shift_ovf;
    logic          is_multi;

    assign shift_ovf = ({1'b0, InputB} >= (W + 1)'(W));
    assign is_multi  = (OP == OP_MUL) || (OP == OP_DIV);

    always_comb begin
        sc_out  = '0;
        sc_cond = 1'b0;
        sc_ill  = 1'b0;
        unique case (OP)
            OP_ADD: sc_out = InputA + InputB;
            OP_SUB: sc_out = InputA - InputB;
            OP_AND: sc_out = InputA & InputB;
            OP_OR:  sc_out = InputA | InputB;
            OP_NOT: sc_out = ~InputA;
            OP_XOR: sc_out = InputA ^ InputB;
            OP_LSH: sc_out = shift_ovf ? '0 : (InputA << InputB);
            OP_RSH: sc_out = shift_ovf ? '0 : (InputA >> InputB);
            OP_SLT: begin
                sc_cond = (InputA < InputB);
                sc_out  = {{(W-1){1'b0}}, sc_cond};
            end
            OP_SEQ: begin
                sc_cond = (InputA == InputB);
                sc_out  = {{(W-1){1'b0}}, sc_cond};
            end
            OP_MUL, OP_DIV: sc_out = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // One MUL step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the {carry, hi, lo} pair right.
    logic [W:0]    mul_sum;
    // One DIV step: shift the next dividend bit into the partial remainder
    // and subtract the divisor if it fits. A zero divisor always "fits",
    // which naturally yields an all-ones quotient and remainder = dividend.
    logic [W:0]    div_r;
    logic [W+1:0]  div_diff;
    logic          div_take;
    logic [W-1:0]  step_hi;
    logic [W-1:0]  step_lo;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_r    = {hi_q, lo_q[W-1]};
        div_diff = {1'b0, div_r} - {2'b00, opb_q};
        div_take = ~div_diff[W+1];
        if (is_div_q) begin
            step_hi = div_take ? div_diff[W-1:0] : div_r[W-1:0];
            step_lo = {lo_q[W-2:0], div_take};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        out_d    = out_q;
        outhi_d  = outhi_q;
        cond_d   = cond_q;
        zero_d   = zero_q;
        divz_d   = divz_q;
        ill_d    = ill_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start && is_multi) begin
                    state_d  = S_RUN;
                    cnt_d    = CW'(W);
                    hi_d     = '0;
                    lo_d     = InputA;
                    opb_d    = InputB;
                    is_div_d = (OP == OP_DIV);
                    busy_d   = 1'b1;
                end else if (Start) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    out_d   = sc_out;
                    outhi_d = '0;
                    cond_d  = sc_cond;
                    zero_d  = (sc_out == '0);
                    divz_d  = 1'b0;
                    ill_d   = sc_ill;
                end
            end
            S_RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    out_d   = step_lo;
                    outhi_d = step_hi;
                    cond_d  = 1'b0;
                    zero_d  = (step_lo == '0);
                    divz_d  = is_div_q && (opb_q == '0);
                    ill_d   = 1'b0;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            outhi_q  <= '0;
            cond_q   <= 1'b0;
            zero_q   <= 1'b0;
            divz_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
            outhi_q  <= outhi_d;
            cond_q   <= cond_d;
            zero_q   <= zero_d;
            divz_q   <= divz_d;
            ill_q    <= ill_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Out     = out_q;
    assign OutHi   = outhi_q;
    assign Cond    = cond_q;
    assign Zero    = zero_q;
    assign DivZero = divz_q;
    assign Illegal = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed stimulus for seq_alu (W=8) with a cycle-level
// behavioural model compared on every falling clock edge.
module tb_seq_alu;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic [3:0] OP;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       Busy;
    logic       Done;
    logic [7:0] Out;
    logic [7:0] OutHi;
    logic       Cond;
    logic       Zero;
    logic       DivZero;
    logic       Illegal;

    int checks;
    int failures;

    seq_alu #(.W(8), .Ops(4)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .Start(Start),
        .OP(OP),
        .InputA(InputA),
        .InputB(InputB),
        .Busy(Busy),
        .Done(Done),
        .Out(Out),
        .OutHi(OutHi),
        .Cond(Cond),
        .Zero(Zero),
        .DivZero(DivZero),
        .Illegal(Illegal)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference arithmetic straight from the op definitions
    task automatic model_op(input int op, input int a, input int b,
                            output int o, output int h, output bit c,
                            output bit dz, output bit il);
        int p;
        o = 0; h = 0; c = 0; dz = 0; il = 0;
        case (op)
            0: o = (a + b) & 255;
            1: o = (a - b) & 255;
            2: o = a & b;
            3: o = a | b;
            4: o = (~a) & 255;
            5: o = a ^ b;
            6: o = (b >= 8) ? 0 : ((a << b) & 255);
            7: o = (b >= 8) ? 0 : (a >> b);
            8: begin c = (a < b); o = int'(c); end
            9: begin c = (a == b); o = int'(c); end
            10: begin p = a * b; o = p & 255; h = p >> 8; end
            11: begin
                if (b == 0) begin o = 255; h = a; dz = 1; end
                else begin o = a / b; h = a % b; end
            end
            default: il = 1;
        endcase
    endtask

    // Model: an accepted op commits W edges later (multi) or at the accept
    // edge (single); a new op is accepted two edges after the last commit.
    int  edge_cnt, last_done, commit_edge;
    bit  pending;
    int  p_out, p_hi;
    bit  p_cond, p_dz, p_il;
    int  e_out, e_hi;
    bit  e_cond, e_zero, e_dz, e_il, e_done, e_busy;

    task automatic model_reset();
        edge_cnt = 0; last_done = -10; commit_edge = 0; pending = 0;
        e_out = 0; e_hi = 0; e_cond = 0; e_zero = 0; e_dz = 0; e_il = 0;
        e_done = 0; e_busy = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (!Reset_n) begin
                model_reset();
            end else begin
                edge_cnt++;
                e_done = 0;
                if (Start && !pending && edge_cnt >= last_done + 2) begin
                    model_op(int'(OP), int'(InputA), int'(InputB),
                             p_out, p_hi, p_cond, p_dz, p_il);
                    pending = 1;
                    commit_edge = edge_cnt + ((OP == 10 || OP == 11) ? 8 : 0);
                    last_done = commit_edge;
                end
                if (pending && edge_cnt == commit_edge) begin
                    e_out = p_out; e_hi = p_hi; e_cond = p_cond;
                    e_zero = (p_out == 0); e_dz = p_dz; e_il = p_il;
                    e_done = 1; pending = 0;
                end
                e_busy = pending;
            end
        end
    end

    bit cmp_en = 0;
    initial begin
        forever begin
            @(negedge Clk);
            if (cmp_en) begin
                chk("m_busy", Busy, e_busy);
                chk("m_done", Done, e_done);
                chk("m_out", Out, e_out);
                chk("m_outhi", OutHi, e_hi);
                chk("m_cond", Cond, e_cond);
                chk("m_zero", Zero, e_zero);
                chk("m_divzero", DivZero, e_dz);
                chk("m_illegal", Illegal, e_il);
            end
        end
    end

    // Launch one op and wait (bounded) for Done; lat counts falling edges
    // after the accepting edge, i.e. Done in cycle n+lat.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat);
        int n;
        @(negedge Clk);
        Start = 1'b1; OP = op; InputA = a; InputB = b;
        @(negedge Clk);
        Start = 1'b0;
        n = 1;
        while (!Done && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk({name, "_lat"}, n, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] held;
    int dcount;

    initial begin
        checks = 0; failures = 0;
        Reset_n = 1'b0; Start = 1'b0; OP = '0; InputA = '0; InputB = '0;
        #2;
        chk("rst_out", {Busy, Done, Out, OutHi, Cond, Zero, DivZero, Illegal}, 0);
        cmp_en = 1;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        run_op("add", 4'd0, 8'hF0, 8'h20, 1);
        chk("add_out", Out, 8'h10);
        chk("add_hi", OutHi, 8'h00);
        chk("add_zero", Zero, 1'b0);

        run_op("mul1", 4'd10, 8'd200, 8'd200, 9);
        chk("mul1_out", Out, 8'h40);
        chk("mul1_hi", OutHi, 8'h9C);
        run_op("mul2", 4'd10, 8'd13, 8'd11, 9);
        chk("mul2_out", Out, 8'h8F);
        chk("mul2_hi", OutHi, 8'h00);

        run_op("div1", 4'd11, 8'd100, 8'd7, 9);
        chk("div1_out", Out, 8'd14);
        chk("div1_hi", OutHi, 8'd2);
        chk("div1_dz", DivZero, 1'b0);
        run_op("div0", 4'd11, 8'h55, 8'h00, 9);
        chk("div0_out", Out, 8'hFF);
        chk("div0_hi", OutHi, 8'h55);
        chk("div0_dz", DivZero, 1'b1);

        run_op("slt", 4'd8, 8'd3, 8'd5, 1);
        chk("slt_out", Out, 8'd1);
        chk("slt_cond", Cond, 1'b1);
        chk("slt_dzclr", DivZero, 1'b0);
        run_op("seq", 4'd9, 8'd3, 8'd5, 1);
        chk("seq_out", Out, 8'd0);
        chk("seq_cond", Cond, 1'b0);
        chk("seq_zero", Zero, 1'b1);
        run_op("lsh", 4'd6, 8'd1, 8'd9, 1);
        chk("lsh_out", Out, 8'd0);
        run_op("lsh3", 4'd6, 8'h11, 8'd3, 1);
        chk("lsh3_out", Out, 8'h88);
        run_op("rsh7", 4'd7, 8'h80, 8'd7, 1);
        chk("rsh7_out", Out, 8'h01);
        run_op("sub", 4'd1, 8'd5, 8'd7, 1);
        chk("sub_out", Out, 8'hFE);
        run_op("not", 4'd4, 8'h0F, 8'hAA, 1);
        chk("not_out", Out, 8'hF0);
        run_op("ill", 4'd13, 8'h12, 8'h34, 1);
        chk("ill_flag", Illegal, 1'b1);
        chk("ill_out", Out, 8'h00);

        // Starts during RUN and during the Done cycle are ignored
        @(negedge Clk);
        Start = 1'b1; OP = 4'd10; InputA = 8'd200; InputB = 8'd200;
        @(negedge Clk);
        Start = 1'b0; held = Out;
        @(negedge Clk);
        @(negedge Clk);
        Start = 1'b1; OP = 4'd0; InputA = 8'd1; InputB = 8'd1;
        @(negedge Clk);
        Start = 1'b0;
        chk("ign_hold", Out, held);
        chk("ign_busy", Busy, 1'b1);
        repeat (5) @(negedge Clk);
        chk("ign_done", Done, 1'b1);
        chk("ign_out", Out, 8'h40);
        chk("ign_hi", OutHi, 8'h9C);
        Start = 1'b1; OP = 4'd0; InputA = 8'd1; InputB = 8'd1;
        @(negedge Clk);
        Start = 1'b0;
        dcount = 0;
        repeat (6) begin
            @(negedge Clk);
            if (Done) dcount++;
        end
        chk("ign_nodone", dcount, 0);

        // Asynchronous reset in the middle of a DIV
        @(negedge Clk);
        Start = 1'b1; OP = 4'd11; InputA = 8'd100; InputB = 8'd7;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("mid_busy", Busy, 1'b1);
        #3 Reset_n = 1'b0;
        #1;
        chk("mid_rst", {Busy, Done, Out, OutHi, Cond, Zero, DivZero, Illegal}, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Done) dcount++;
        end
        chk("rst_nodone", dcount, 0);
        run_op("add2", 4'd0, 8'd3, 8'd4, 1);
        chk("add2_out", Out, 8'd7);

        @(negedge Clk);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
